// File: rtl/usb_uart_pkg.sv
// Shared register bit positions and FSM encodings for the USB-UART bridge.
package usb_uart_pkg;

  // CTRL register bits
  localparam int unsigned CtrlRxIe  = 0;
  localparam int unsigned CtrlTxIe  = 1;
  localparam int unsigned CtrlRxClr = 6;
  localparam int unsigned CtrlTxClr = 7;

  // STAT register bits
  localparam int unsigned StatRxNe   = 0;
  localparam int unsigned StatRxFull = 1;
  localparam int unsigned StatTxMt   = 2;
  localparam int unsigned StatTxFull = 3;
  localparam int unsigned StatRxOvr  = 4;
  localparam int unsigned StatRxFerr = 5;
  localparam int unsigned StatTxOvf  = 6;
  localparam int unsigned StatTxBusy = 7;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign head_o  = mem_q[rptr_q[AddrW-1:0]];

  // A pop frees a slot, so a push into a full FIFO is accepted in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  // Pointer next-state; clear wins over push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/usb_uart.sv
// 8N1 UART with RX/TX FIFOs behind a CTRL/STAT/DATA register interface.
module usb_uart
  import usb_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 417,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] reg_d_i,
  output logic [7:0] reg_d_o,
  input  logic       reg_wr_i,
  input  logic       reg_rd_i,
  input  logic       cs_ctrl_i,
  input  logic       cs_stat_i,
  input  logic       cs_data_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       irq_o
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

  logic ctrl_wr, stat_rd, data_wr, data_rd, rx_clr, tx_clr;
  assign ctrl_wr = reg_wr_i & cs_ctrl_i;
  assign stat_rd = reg_rd_i & cs_stat_i;
  assign data_wr = reg_wr_i & cs_data_i;
  assign data_rd = reg_rd_i & cs_data_i;
  assign rx_clr  = ctrl_wr & reg_d_i[CtrlRxClr];
  assign tx_clr  = ctrl_wr & reg_d_i[CtrlTxClr];

  logic [1:0] ctrl_q;
  logic       rx_ovr_q, rx_ferr_q, tx_ovf_q, irq_q;
  logic       tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, ferr_set;
  logic [7:0] tx_head, rx_head;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d, tx_done;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;

  fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (data_wr),
    .pop_i   (tx_pop),
    .clear_i (tx_clr),
    .data_i  (reg_d_i),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (rx_push),
    .pop_i   (data_rd),
    .clear_i (rx_clr),
    .data_i  (rx_shift_q),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  // TX next-state: a new byte is popped and loaded on every entry to TxStart.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_done    = (tx_cnt_q == BitLast);
    tx_cnt_d   = tx_done ? '0 : tx_cnt_q + CntW'(1);
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!tx_empty && !tx_clr) begin
          tx_state_d = TxStart;
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
        end
      end
      TxStart: if (tx_done) begin
        tx_state_d = TxData;
        tx_bit_d   = '0;
      end
      TxData: if (tx_done) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = TxStop;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end
      TxStop: if (tx_done) begin
        if (!tx_empty && !tx_clr) begin
          tx_state_d = TxStart;
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
        end else begin
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Line level is registered from the next state so tx_o never glitches.
    case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX next-state: start is qualified at half-bit, then sampled every full bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RxIdle : RxData;
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_cnt_d = '0;
        if (rx_sync_q) begin
          rx_push    = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          ferr_set   = 1'b1;
          rx_state_d = RxWaitHigh;
        end
      end
      RxWaitHigh: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // State, datapath, sticky flags and interrupt registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q     <= '0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      if (ctrl_wr) ctrl_q <= reg_d_i[1:0];
      // Set beats the read-clear in the same cycle.
      rx_ovr_q   <= (rx_push & rx_full & ~data_rd) | (rx_ovr_q & ~stat_rd);
      rx_ferr_q  <= ferr_set | (rx_ferr_q & ~stat_rd);
      tx_ovf_q   <= (data_wr & tx_full & ~tx_pop) | (tx_ovf_q & ~stat_rd);
      irq_q      <= (ctrl_q[CtrlRxIe] & ~rx_empty) | (ctrl_q[CtrlTxIe] & tx_empty);
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  // Register read mux.
  always_comb begin
    logic [7:0] stat;
    stat             = '0;
    stat[StatRxNe]   = ~rx_empty;
    stat[StatRxFull] = rx_full;
    stat[StatTxMt]   = tx_empty;
    stat[StatTxFull] = tx_full;
    stat[StatRxOvr]  = rx_ovr_q;
    stat[StatRxFerr] = rx_ferr_q;
    stat[StatTxOvf]  = tx_ovf_q;
    stat[StatTxBusy] = (tx_state_q != TxIdle);
    reg_d_o = 8'h00;
    if (cs_ctrl_i)      reg_d_o = {6'b0, ctrl_q};
    else if (cs_stat_i) reg_d_o = stat;
    else if (cs_data_i) reg_d_o = rx_empty ? 8'h00 : rx_head;
  end

  assign tx_o  = tx_q;
  assign irq_o = irq_q;

endmodule
